// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the BCD<->binary conversion paths.
package bcd_pkg;

  localparam int DIGITS_DEFAULT     = 8;
  localparam int WIDTH_DEFAULT      = 32;

  localparam int BCD_DIGIT_MAX      = 9;
  localparam int BCD_CORRECT_THRESH = 8;
  localparam int BCD_CORRECT_VAL    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // True when a 4-bit nibble is not a legal decimal digit.
  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > 4'(BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble digit correction: a nibble that reads 8 or more
// after the right shift absorbed a carried-down tens bit, so remove 3.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Conditional subtract-3 on a single digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'(BCD_CORRECT_THRESH)) begin
      digit_o = digit_i - 4'(BCD_CORRECT_VAL);
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Signed packed BCD to two's-complement binary, one reverse double-dabble
// step per clock with a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; captures operands on accept
// SHIFT  | one shift-right/correct step per clock, 4*DIGITS steps
// FINISH | one-cycle done pulse; binary/invalid already updated
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT,
  parameter int WIDTH  = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                neg,
  output logic [WIDTH-1:0]    binary,
  output logic                busy,
  output logic                done,
  output logic                invalid
);

  localparam int BITS     = 4 * DIGITS;
  localparam int CNT_W    = $clog2(BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);

  state_e             state_q, state_d;
  logic [BITS-1:0]    bcd_sr_q, bcd_sr_d;
  logic [BITS-1:0]    bin_sr_q, bin_sr_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   binary_q, binary_d;
  logic               invalid_q, invalid_d;

  logic [2*BITS-1:0]  shifted;
  logic [BITS-1:0]    bcd_step;
  logic [BITS-1:0]    bin_step;
  logic [WIDTH-1:0]   mag;
  logic               any_bad;
  logic               accept;
  logic               last_step;

  assign shifted   = {bcd_sr_q, bin_sr_q} >> 1;
  assign bin_step  = shifted[BITS-1:0];
  assign mag       = WIDTH'(bin_step);
  assign accept    = (state_q == IDLE) && start;
  assign last_step = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_correct u_corr (
      .digit_i (shifted[BITS + 4*g +: 4]),
      .digit_o (bcd_step[4*g +: 4])
    );
  end

  // Flag any non-decimal digit on the incoming operand.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_in[4*i +: 4])) any_bad = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; bad digits skip straight to FINISH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = any_bad ? FINISH : SHIFT;
      SHIFT:   if (last_step) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; busy and done are mutually exclusive by construction.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == FINISH);
  end

  // Datapath next values: capture on accept, step in SHIFT, publish result on the last step.
  always_comb begin
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    binary_d  = binary_q;
    invalid_d = invalid_q;
    if (accept) begin
      bcd_sr_d  = bcd_in;
      neg_d     = neg;
      bin_sr_d  = '0;
      cnt_d     = '0;
      invalid_d = any_bad;
      if (any_bad) binary_d = '0;
    end else if (state_q == SHIFT) begin
      bcd_sr_d = bcd_step;
      bin_sr_d = bin_step;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_step) begin
        // Negating zero yields zero, so no negative-zero special case is needed.
        binary_d = neg_q ? (~mag + WIDTH'(1)) : mag;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      binary_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      binary_q  <= binary_d;
      invalid_q <= invalid_d;
    end
  end

  assign binary  = binary_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized and directed checks of bcd_to_binary_seq against a decimal reference model.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 32;
  localparam int STEPS  = 4 * DIGITS;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                neg = 1'b0;
  logic [WIDTH-1:0]    binary;
  logic                busy;
  logic                done;
  logic                invalid;

  int checks = 0;
  int failures = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .neg     (neg),
    .binary  (binary),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits, negated if requested.
  function automatic void ref_conv(input logic [4*DIGITS-1:0] b, input logic n,
                                   output logic [WIDTH-1:0] res, output logic bad);
    longint val = 0;
    longint scale = 1;
    logic [4*DIGITS-1:0] v = b;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      val += longint'(d) * scale;
      scale *= 10;
    end
    if (bad) res = '0;
    else     res = n ? WIDTH'(-val) : WIDTH'(val);
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd(input bit allow_bad);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // Called #1 after an edge with the DUT in IDLE; runs one conversion end to end.
  task automatic run_conv(input string tag, input logic [4*DIGITS-1:0] b, input logic n,
                          input bit noise);
    logic [WIDTH-1:0] exp_bin;
    logic exp_bad;
    int lat;
    bit seen;
    ref_conv(b, n, exp_bin, exp_bad);
    start = 1'b1; bcd_in = b; neg = n;
    @(posedge clk); #1;
    start = 1'b0;
    bcd_in = $urandom; neg = 1'($urandom);
    chk({tag, " busy_after_accept"}, 64'(busy), 64'(!exp_bad));
    lat = 0; seen = done;
    while (!seen && lat < 100) begin
      if (noise) start = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'(1));
    chk({tag, " latency"}, 64'(lat), 64'(exp_bad ? 0 : STEPS));
    chk({tag, " busy_with_done"}, 64'(busy), 64'(0));
    chk({tag, " binary"}, 64'(binary), 64'(exp_bin));
    chk({tag, " invalid"}, 64'(invalid), 64'(exp_bad));
    @(posedge clk); #1;
    chk({tag, " done_pulse_width"}, 64'(done), 64'(0));
    chk({tag, " binary_hold"}, 64'(binary), 64'(exp_bin));
  endtask

  initial begin
    int dn;
    int done_at [$];
    logic [4*DIGITS-1:0] rb;

    // Reset state
    #2;
    chk("reset binary", 64'(binary), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset invalid", 64'(invalid), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_conv("d12345678", 32'h12345678, 1'b0, 1'b0);
    run_conv("d99999999n", 32'h99999999, 1'b1, 1'b0);
    run_conv("dnegzero", 32'h00000000, 1'b1, 1'b0);
    run_conv("dbad12A", 32'h0000012A, 1'b0, 1'b0);
    run_conv("dclearinv", 32'h00000042, 1'b0, 1'b0);

    // Reset mid-conversion
    start = 1'b1; bcd_in = 32'h00000255; neg = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst binary", 64'(binary), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    chk("midrst no_done", 64'(dn), 64'(0));
    run_conv("restart255", 32'h00000255, 1'b0, 1'b0);

    // Start pulses while busy are ignored
    run_conv("noise", 32'h00031415, 1'b1, 1'b1);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    chk("noise extra_done", 64'(dn), 64'(0));

    // Randomized conversions
    for (int t = 0; t < 24; t++) begin
      rb = rand_bcd(1'b1);
      run_conv($sformatf("rand%0d", t), rb, 1'($urandom), 1'(t % 3 == 0));
    end

    // Start held high continuously
    start = 1'b1; bcd_in = 32'h00000001; neg = 1'b0;
    for (int c = 0; c < 34 * 5 + 5; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(c);
        chk("held binary", 64'(binary), 64'(1));
        chk("held busy", 64'(busy), 64'(0));
      end
    end
    start = 1'b0;
    chk("held count", 64'(done_at.size() >= 4), 64'(1));
    for (int i = 1; i < done_at.size(); i++)
      chk("held period", 64'(done_at[i] - done_at[i-1]), 64'(34));
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
